// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with load-use hazard detection, EX hold, branch flush and bubble insertion.
// Optional performance counters (bubble_cnt, flush_cnt) are enabled by defining ID_EX_PERF_EN.
module id_ex_pipe_reg #(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               id_valid,
  input  logic [5:0]         id_ctrl,
  input  logic [XLEN-1:0]    id_pc,
  input  logic [XLEN-1:0]    id_rs1_data,
  input  logic [XLEN-1:0]    id_rs2_data,
  input  logic [XLEN-1:0]    id_imm,
  input  logic [RADDR_W-1:0] id_rs1,
  input  logic [RADDR_W-1:0] id_rs2,
  input  logic [RADDR_W-1:0] id_rd,
  input  logic [3:0]         id_funct,
  input  logic               ex_hold,
  input  logic               flush,
  output logic               load_use_stall,
  output logic               ex_valid,
  output logic [5:0]         ex_ctrl,
  output logic [XLEN-1:0]    ex_pc,
  output logic [XLEN-1:0]    ex_rs1_data,
  output logic [XLEN-1:0]    ex_rs2_data,
  output logic [XLEN-1:0]    ex_imm,
  output logic [RADDR_W-1:0] ex_rs1,
  output logic [RADDR_W-1:0] ex_rs2,
  output logic [RADDR_W-1:0] ex_rd,
  output logic [3:0]         ex_funct
`ifdef ID_EX_PERF_EN
  ,
  output logic [31:0]        bubble_cnt,
  output logic [31:0]        flush_cnt
`endif
);

  // Bit position of MemRead inside {ALUSrc,MemtoReg,RegWrite,MemRead,MemWrite,Branch}.
  localparam int CTRL_MEMREAD = 2;

  // x0 is hardwired to zero, so a load targeting it can never create a hazard.
  assign load_use_stall = ex_valid & ex_ctrl[CTRL_MEMREAD] & (ex_rd != '0) & id_valid &
                          ((ex_rd == id_rs1) | (ex_rd == id_rs2));

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid    <= 1'b0;
      ex_ctrl     <= '0;
      ex_pc       <= '0;
      ex_rs1_data <= '0;
      ex_rs2_data <= '0;
      ex_imm      <= '0;
      ex_rs1      <= '0;
      ex_rs2      <= '0;
      ex_rd       <= '0;
      ex_funct    <= '0;
    end else if (flush) begin
      // Branch resolution kills the slot even while EX is busy.
      ex_valid    <= 1'b0;
      ex_ctrl     <= '0;
      ex_pc       <= '0;
      ex_rs1_data <= '0;
      ex_rs2_data <= '0;
      ex_imm      <= '0;
      ex_rs1      <= '0;
      ex_rs2      <= '0;
      ex_rd       <= '0;
      ex_funct    <= '0;
    end else if (ex_hold) begin
      ex_valid <= ex_valid;
    end else if (load_use_stall) begin
      // Bubble: clearing MemRead releases the stall on the next cycle.
      ex_valid <= 1'b0;
      ex_ctrl  <= '0;
      ex_rd    <= '0;
    end else begin
      ex_valid    <= id_valid;
      ex_ctrl     <= id_valid ? id_ctrl : '0;
      ex_pc       <= id_pc;
      ex_rs1_data <= id_rs1_data;
      ex_rs2_data <= id_rs2_data;
      ex_imm      <= id_imm;
      ex_rs1      <= id_rs1;
      ex_rs2      <= id_rs2;
      ex_rd       <= id_rd;
      ex_funct    <= id_funct;
    end
  end

`ifdef ID_EX_PERF_EN
  logic bubble_taken;
  assign bubble_taken = !flush && !ex_hold && load_use_stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bubble_cnt <= '0;
      flush_cnt  <= '0;
    end else begin
      bubble_cnt <= bubble_cnt + {31'd0, bubble_taken};
      flush_cnt  <= flush_cnt + {31'd0, flush};
    end
  end
`endif

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Self-checking bench for id_ex_pipe_reg: table-driven stream plus reset and counter sequences.
// Counter checks are compiled in when ID_EX_PERF_EN is defined.
module tb_id_ex_pipe_reg;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic [5:0]  id_ctrl;
  logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [3:0]  id_funct;
  logic        ex_hold, flush;
  logic        load_use_stall, ex_valid;
  logic [5:0]  ex_ctrl;
  logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic [3:0]  ex_funct;
`ifdef ID_EX_PERF_EN
  logic [31:0] bubble_cnt, flush_cnt;
`endif

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  id_ex_pipe_reg #(.XLEN(32), .RADDR_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_ctrl(id_ctrl), .id_pc(id_pc),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_funct(id_funct),
    .ex_hold(ex_hold), .flush(flush), .load_use_stall(load_use_stall),
    .ex_valid(ex_valid), .ex_ctrl(ex_ctrl), .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data),
    .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .ex_rd(ex_rd), .ex_funct(ex_funct)
`ifdef ID_EX_PERF_EN
    , .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
`endif
  );

  typedef struct {
    logic        valid;
    logic [5:0]  ctrl;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] imm;
    logic        hold, flush;
    logic        e_stall, e_valid;
    logic [5:0]  e_ctrl;
    logic [4:0]  e_rd;
    logic [31:0] e_imm;
    logic        chk_rd, chk_imm;
  } vec_t;

  vec_t tbl[21];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic v, input logic [5:0] c, input logic [4:0] r1,
                              input logic [4:0] r2, input logic [4:0] rd, input logic [31:0] im,
                              input logic h, input logic f, input logic es, input logic ev,
                              input logic [5:0] ec, input logic [4:0] erd, input logic [31:0] eim,
                              input logic crd, input logic cim);
    vec_t t;
    t.valid = v; t.ctrl = c; t.rs1 = r1; t.rs2 = r2; t.rd = rd; t.imm = im;
    t.hold = h; t.flush = f; t.e_stall = es; t.e_valid = ev; t.e_ctrl = ec;
    t.e_rd = erd; t.e_imm = eim; t.chk_rd = crd; t.chk_imm = cim;
    return t;
  endfunction

  // Side fields are derived from the immediate so their expected copies are derivable too.
  task automatic drive(input logic v, input logic [5:0] c, input logic [4:0] r1,
                       input logic [4:0] r2, input logic [4:0] rd, input logic [31:0] im,
                       input logic h, input logic f);
    id_valid = v; id_ctrl = c; id_rs1 = r1; id_rs2 = r2; id_rd = rd; id_imm = im;
    id_pc = im << 2; id_rs1_data = im + 32'd1; id_rs2_data = im + 32'd2; id_funct = im[7:4];
    ex_hold = h; flush = f;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, 64'(ex_valid), 64'd0);
    check({tag, "_ctrl"},  64'(ex_ctrl), 64'd0);
    check({tag, "_pc"},    64'(ex_pc), 64'd0);
    check({tag, "_rs1d"},  64'(ex_rs1_data), 64'd0);
    check({tag, "_rs2d"},  64'(ex_rs2_data), 64'd0);
    check({tag, "_imm"},   64'(ex_imm), 64'd0);
    check({tag, "_regs"},  64'({ex_rs1, ex_rs2, ex_rd}), 64'd0);
    check({tag, "_funct"}, 64'(ex_funct), 64'd0);
    check({tag, "_stall"}, 64'(load_use_stall), 64'd0);
  endtask

  initial begin
    // lw = 6'b111100 (MemRead set), alu-imm = 6'b101000, alu-reg = 6'b001000
    tbl[0]  = mk(1, 6'b101000, 1, 2, 5, 32'h10, 0, 0,  0, 1, 6'b101000, 5, 32'h10, 1, 1);
    tbl[1]  = mk(1, 6'b111100, 3, 4, 7, 32'h20, 0, 0,  0, 1, 6'b111100, 7, 32'h20, 1, 1);
    tbl[2]  = mk(1, 6'b001000, 1, 7, 8, 32'h30, 0, 0,  1, 0, 6'b000000, 0, 32'h0,  1, 0);
    tbl[3]  = mk(1, 6'b001000, 1, 7, 8, 32'h30, 0, 0,  0, 1, 6'b001000, 8, 32'h30, 1, 1);
    tbl[4]  = mk(1, 6'b111100, 9, 9, 0, 32'h40, 0, 0,  0, 1, 6'b111100, 0, 32'h40, 1, 1);
    tbl[5]  = mk(1, 6'b101000, 0, 0, 10, 32'h50, 0, 0, 0, 1, 6'b101000, 10, 32'h50, 1, 1);
    tbl[6]  = mk(0, 6'b111111, 1, 2, 11, 32'h60, 0, 0, 0, 0, 6'b000000, 11, 32'h60, 1, 1);
    tbl[7]  = mk(1, 6'b111100, 1, 2, 12, 32'h70, 0, 0, 0, 1, 6'b111100, 12, 32'h70, 1, 1);
    tbl[8]  = mk(0, 6'b001000, 12, 2, 13, 32'h80, 0, 0, 0, 0, 6'b000000, 13, 32'h80, 1, 1);
    tbl[9]  = mk(1, 6'b111100, 1, 2, 14, 32'h90, 0, 0, 0, 1, 6'b111100, 14, 32'h90, 1, 1);
    tbl[10] = mk(1, 6'b001000, 14, 2, 15, 32'hA0, 1, 1, 1, 0, 6'b000000, 0, 32'h0, 0, 0);
    tbl[11] = mk(1, 6'b101000, 1, 2, 16, 32'hA0, 0, 0, 0, 1, 6'b101000, 16, 32'hA0, 1, 1);
    tbl[12] = mk(1, 6'b111100, 3, 4, 17, 32'hB0, 1, 0, 0, 1, 6'b101000, 16, 32'hA0, 1, 1);
    tbl[13] = mk(1, 6'b111100, 3, 4, 17, 32'hB0, 1, 0, 0, 1, 6'b101000, 16, 32'hA0, 1, 1);
    tbl[14] = mk(1, 6'b111100, 3, 4, 17, 32'hB0, 1, 0, 0, 1, 6'b101000, 16, 32'hA0, 1, 1);
    tbl[15] = mk(1, 6'b111100, 1, 2, 18, 32'hC0, 0, 0, 0, 1, 6'b111100, 18, 32'hC0, 1, 1);
    tbl[16] = mk(1, 6'b001000, 18, 3, 19, 32'hD0, 1, 0, 1, 1, 6'b111100, 18, 32'hC0, 1, 1);
    tbl[17] = mk(1, 6'b001000, 18, 3, 19, 32'hD0, 0, 0, 1, 0, 6'b000000, 0, 32'h0, 1, 0);
    tbl[18] = mk(1, 6'b001000, 18, 3, 19, 32'hD0, 0, 0, 0, 1, 6'b001000, 19, 32'hD0, 1, 1);
    tbl[19] = mk(1, 6'b101000, 1, 2, 20, 32'hE0, 0, 1, 0, 0, 6'b000000, 0, 32'h0, 0, 0);
    tbl[20] = mk(0, 6'b101000, 1, 2, 21, 32'hF0, 0, 1, 0, 0, 6'b000000, 0, 32'h0, 0, 0);

    rst_n = 1'b0;
    drive(1, 6'b111100, 1, 2, 3, 32'h55, 0, 0);
    #1;
    check_all_zero("reset");
`ifdef ID_EX_PERF_EN
    check("reset_bubble_cnt", 64'(bubble_cnt), 64'd0);
    check("reset_flush_cnt", 64'(flush_cnt), 64'd0);
`endif
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 21; i++) begin
      if (i != 0) @(negedge clk);
      drive(tbl[i].valid, tbl[i].ctrl, tbl[i].rs1, tbl[i].rs2, tbl[i].rd, tbl[i].imm,
            tbl[i].hold, tbl[i].flush);
      #1;
      check($sformatf("v%0d_stall", i), 64'(load_use_stall), 64'(tbl[i].e_stall));
      @(posedge clk);
      #1;
      check($sformatf("v%0d_valid", i), 64'(ex_valid), 64'(tbl[i].e_valid));
      check($sformatf("v%0d_ctrl", i), 64'(ex_ctrl), 64'(tbl[i].e_ctrl));
      if (tbl[i].chk_rd)
        check($sformatf("v%0d_rd", i), 64'(ex_rd), 64'(tbl[i].e_rd));
      if (tbl[i].chk_imm) begin
        check($sformatf("v%0d_imm", i), 64'(ex_imm), 64'(tbl[i].e_imm));
        check($sformatf("v%0d_pc", i), 64'(ex_pc), 64'(tbl[i].e_imm << 2));
        check($sformatf("v%0d_rs1d", i), 64'(ex_rs1_data), 64'(tbl[i].e_imm + 32'd1));
        check($sformatf("v%0d_rs2d", i), 64'(ex_rs2_data), 64'(tbl[i].e_imm + 32'd2));
        check($sformatf("v%0d_funct", i), 64'(ex_funct), 64'(tbl[i].e_imm[7:4]));
      end
    end

`ifdef ID_EX_PERF_EN
    // Stream above takes two bubbles (v2, v17) and three flushes (v10, v19, v20).
    check("perf_bubble_cnt", 64'(bubble_cnt), 64'd2);
    check("perf_flush_cnt", 64'(flush_cnt), 64'd3);
    @(negedge clk);
    drive(0, 6'b0, 0, 0, 0, 32'h0, 0, 0);
    force dut.flush_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.flush_cnt;
    flush = 1'b1;
    @(posedge clk);
    #1;
    check("perf_flush_wrap", 64'(flush_cnt), 64'd0);
    check("perf_bubble_keep", 64'(bubble_cnt), 64'd2);
`endif

    // Asynchronous reset in the middle of a cycle with a valid instruction in EX.
    @(negedge clk);
    drive(1, 6'b111100, 21, 22, 23, 32'h123, 0, 0);
    @(posedge clk);
    #1;
    check("pre_rst_valid", 64'(ex_valid), 64'd1);
    check("pre_rst_srcs", 64'({ex_rs1, ex_rs2}), 64'({5'd21, 5'd22}));
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
`ifdef ID_EX_PERF_EN
    check("midrst_flush_cnt", 64'(flush_cnt), 64'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 6'b101000, 1, 2, 4, 32'h44, 0, 0);
    @(posedge clk);
    #1;
    check("post_rst_idle_valid", 64'(ex_valid), 64'd0);
    check("post_rst_idle_ctrl", 64'(ex_ctrl), 64'd0);
    @(negedge clk);
    drive(1, 6'b101000, 1, 2, 4, 32'h44, 0, 0);
    @(posedge clk);
    #1;
    check("post_rst_load_valid", 64'(ex_valid), 64'd1);
    check("post_rst_load_ctrl", 64'(ex_ctrl), 64'(6'b101000));
    check("post_rst_load_rd", 64'(ex_rd), 64'd4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
